// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request arbiter slice.
package sdram_pkg;

    localparam int unsigned SDRAM_APP_ADDR_WIDTH = 24;

    typedef enum logic [1:0] {
        OP_REF = 2'd0,
        OP_WR  = 2'd1,
        OP_RD  = 2'd2
    } op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    // True when the controller completion pulse belongs to the outstanding op.
    function automatic logic op_done_match(op_e op, logic wr_done, logic rd_done,
                                           logic ref_done);
        logic match;
        match = 1'b0;
        case (op)
            OP_REF:  match = ref_done;
            OP_WR:   match = wr_done;
            OP_RD:   match = rd_done;
            default: match = 1'b0;
        endcase
        return match;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; ptr selects the favoured requester on a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt_sel
);

    always_comb begin
        gnt_sel = req;
        if (req == 2'b11) begin
            gnt_sel = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Arbitrates refresh and two clients onto the SDRAM controller, one operation at a time,
// with refresh at top priority and round-robin between clients.
module sdram_req_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned APP_ADDR_WIDTH = SDRAM_APP_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYC    = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_init_done,
    input  logic                      i_ref_req,
    output logic                      o_ref_ack,
    input  logic                      i_c0_req,
    input  logic                      i_c0_we,
    input  logic [APP_ADDR_WIDTH-1:0] i_c0_addr,
    input  logic                      i_c1_req,
    input  logic                      i_c1_we,
    input  logic [APP_ADDR_WIDTH-1:0] i_c1_addr,
    output logic                      o_c0_gnt,
    output logic                      o_c1_gnt,
    output logic                      o_c0_done,
    output logic                      o_c1_done,
    output logic                      o_wr_req,
    output logic                      o_rd_req,
    output logic                      o_ref_req,
    output logic [APP_ADDR_WIDTH-1:0] o_cmd_addr,
    input  logic                      i_wr_done,
    input  logic                      i_rd_done,
    input  logic                      i_ref_done,
    output logic                      o_busy,
    output logic                      o_timeout,
    output logic                      o_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Abort fires on the edge where the counter would reach TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);

    state_e                    state_q, state_d;
    op_e                       op_q, op_d;
    logic                      owner_q, owner_d;
    logic                      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [APP_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic                      err_q, err_d;
    logic                      ref_ack_q, ref_ack_d;
    logic                      c0_gnt_q, c0_gnt_d;
    logic                      c1_gnt_q, c1_gnt_d;
    logic                      c0_done_q, c0_done_d;
    logic                      c1_done_q, c1_done_d;
    logic                      wr_req_q, wr_req_d;
    logic                      rd_req_q, rd_req_d;
    logic                      ref_req_q, ref_req_d;
    logic                      timeout_q, timeout_d;

    logic [1:0]                gnt_sel;
    logic                      sel_we;
    logic [APP_ADDR_WIDTH-1:0] sel_addr;
    logic                      done_match;
    logic                      finish;

    rr_arb2 u_rr_arb2 (
        .req     ({i_c1_req, i_c0_req}),
        .ptr     (rr_ptr_q),
        .gnt_sel (gnt_sel)
    );

    assign sel_we     = gnt_sel[1] ? i_c1_we : i_c0_we;
    assign sel_addr   = gnt_sel[1] ? i_c1_addr : i_c0_addr;
    assign done_match = op_done_match(op_q, i_wr_done, i_rd_done, i_ref_done);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        cmd_addr_d = cmd_addr_q;
        err_d      = err_q;
        ref_ack_d  = 1'b0;
        c0_gnt_d   = 1'b0;
        c1_gnt_d   = 1'b0;
        c0_done_d  = 1'b0;
        c1_done_d  = 1'b0;
        wr_req_d   = 1'b0;
        rd_req_d   = 1'b0;
        ref_req_d  = 1'b0;
        timeout_d  = 1'b0;
        finish     = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_init_done) begin
                    if (i_ref_req) begin
                        ref_ack_d = 1'b1;
                        ref_req_d = 1'b1;
                        op_d      = OP_REF;
                        cnt_d     = '0;
                        state_d   = StBusy;
                    end else if (|gnt_sel) begin
                        c0_gnt_d   = gnt_sel[0];
                        c1_gnt_d   = gnt_sel[1];
                        wr_req_d   = sel_we;
                        rd_req_d   = ~sel_we;
                        cmd_addr_d = sel_addr;
                        op_d       = sel_we ? OP_WR : OP_RD;
                        owner_d    = gnt_sel[1];
                        cnt_d      = '0;
                        state_d    = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 1'b1;
                if (done_match) begin
                    finish = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    finish    = 1'b1;
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                end
                if (finish) begin
                    state_d = StIdle;
                    // Refresh has no client owner and must not disturb fairness.
                    if (op_q != OP_REF) begin
                        c0_done_d = ~owner_q;
                        c1_done_d = owner_q;
                        rr_ptr_d  = ~owner_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            op_q       <= OP_REF;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            cmd_addr_q <= '0;
            err_q      <= 1'b0;
            ref_ack_q  <= 1'b0;
            c0_gnt_q   <= 1'b0;
            c1_gnt_q   <= 1'b0;
            c0_done_q  <= 1'b0;
            c1_done_q  <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            ref_req_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            cmd_addr_q <= cmd_addr_d;
            err_q      <= err_d;
            ref_ack_q  <= ref_ack_d;
            c0_gnt_q   <= c0_gnt_d;
            c1_gnt_q   <= c1_gnt_d;
            c0_done_q  <= c0_done_d;
            c1_done_q  <= c1_done_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            ref_req_q  <= ref_req_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_ref_ack  = ref_ack_q;
    assign o_c0_gnt   = c0_gnt_q;
    assign o_c1_gnt   = c1_gnt_q;
    assign o_c0_done  = c0_done_q;
    assign o_c1_done  = c1_done_q;
    assign o_wr_req   = wr_req_q;
    assign o_rd_req   = rd_req_q;
    assign o_ref_req  = ref_req_q;
    assign o_cmd_addr = cmd_addr_q;
    assign o_busy     = (state_q == StBusy);
    assign o_timeout  = timeout_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench for sdram_req_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_sdram_req_arbiter;

    localparam int AW = 24;
    localparam int TO = 8;

    logic          clk;
    logic          rst, init_done, ref_req, c0_req, c1_req, c0_we, c1_we;
    logic [AW-1:0] c0_addr, c1_addr;
    logic          wr_done, rd_done, ref_done;
    logic          ref_ack, c0_gnt, c1_gnt, c0_done, c1_done;
    logic          wr_req, rd_req, ref_cmd, busy, timeout, err;
    logic [AW-1:0] cmd_addr;

    sdram_req_arbiter #(
        .APP_ADDR_WIDTH (AW),
        .TIMEOUT_CYC    (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_init_done (init_done),
        .i_ref_req   (ref_req),
        .o_ref_ack   (ref_ack),
        .i_c0_req    (c0_req),
        .i_c0_we     (c0_we),
        .i_c0_addr   (c0_addr),
        .i_c1_req    (c1_req),
        .i_c1_we     (c1_we),
        .i_c1_addr   (c1_addr),
        .o_c0_gnt    (c0_gnt),
        .o_c1_gnt    (c1_gnt),
        .o_c0_done   (c0_done),
        .o_c1_done   (c1_done),
        .o_wr_req    (wr_req),
        .o_rd_req    (rd_req),
        .o_ref_req   (ref_cmd),
        .o_cmd_addr  (cmd_addr),
        .i_wr_done   (wr_done),
        .i_rd_done   (rd_done),
        .i_ref_done  (ref_done),
        .o_busy      (busy),
        .o_timeout   (timeout),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {ack, g0, g1, d0, d1, wr, rd, ref, busy, timeout, err}
    logic [10:0] flags;
    assign flags = {ref_ack, c0_gnt, c1_gnt, c0_done, c1_done, wr_req, rd_req, ref_cmd,
                    busy, timeout, err};

    // Reference model: one operation in flight, described by what it is and how long it
    // has been running, plus which client gets the next tie.
    bit          m_busy;
    int          m_op;       // 0 refresh, 1 write, 2 read
    int          m_owner;
    int          m_favour;
    int          m_age;
    bit          m_err;
    logic [AW-1:0] m_addr;
    logic [10:0] m_flags;

    task automatic model_step();
        bit e_ack, e_g0, e_g1, e_d0, e_d1, e_wr, e_rd, e_rf, e_to, matched;
        int w;
        bit we;
        {e_ack, e_g0, e_g1, e_d0, e_d1, e_wr, e_rd, e_rf, e_to} = '0;
        if (rst) begin
            m_busy = 0; m_op = 0; m_owner = 0; m_favour = 0; m_age = 0; m_err = 0;
            m_addr = '0;
        end else if (!m_busy) begin
            if (init_done && ref_req) begin
                e_ack = 1; e_rf = 1; m_op = 0; m_busy = 1; m_age = 0;
            end else if (init_done && (c0_req || c1_req)) begin
                w = (c0_req && c1_req) ? m_favour : (c0_req ? 0 : 1);
                we = (w == 0) ? c0_we : c1_we;
                m_addr = (w == 0) ? c0_addr : c1_addr;
                m_op = we ? 1 : 2;
                m_owner = w; m_busy = 1; m_age = 0;
                e_g0 = (w == 0); e_g1 = (w == 1); e_wr = we; e_rd = !we;
            end
        end else begin
            m_age++;
            matched = (m_op == 0 && ref_done) || (m_op == 1 && wr_done) ||
                      (m_op == 2 && rd_done);
            if (matched || m_age == TO - 1) begin
                if (!matched) begin
                    e_to = 1; m_err = 1;
                end
                m_busy = 0;
                if (m_op != 0) begin
                    e_d0 = (m_owner == 0); e_d1 = (m_owner == 1);
                    m_favour = 1 - m_owner;
                end
            end
        end
        m_flags = {e_ack, e_g0, e_g1, e_d0, e_d1, e_wr, e_rd, e_rf, m_busy, e_to, m_err};
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model", {29'd0, flags, cmd_addr}, {29'd0, m_flags, m_addr});
    endtask

    typedef struct packed {
        logic [7:0]    in;    // {rst, init, ref_req, c0_req, c1_req, wr_done, rd_done, ref_done}
        logic [10:0]   exp;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t tbl [15];
    int   n;
    bit   seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {rst, init_done, ref_req, c0_req, c1_req, wr_done, rd_done, ref_done} = 8'b1000_0000;
        c0_we = 1'b1; c1_we = 1'b0; c0_addr = 24'h000010; c1_addr = 24'h000200;
        m_busy = 0; m_op = 0; m_owner = 0; m_favour = 0; m_age = 0; m_err = 0; m_addr = '0;

        tbl[0]  = '{8'b1000_0000, 11'b00000000000, 24'h000000};
        tbl[1]  = '{8'b0001_0000, 11'b00000000000, 24'h000000};
        tbl[2]  = '{8'b0001_0000, 11'b00000000000, 24'h000000};
        tbl[3]  = '{8'b0101_0000, 11'b01000100100, 24'h000010};
        tbl[4]  = '{8'b0100_0010, 11'b00000000100, 24'h000010};
        tbl[5]  = '{8'b0100_0100, 11'b00010000000, 24'h000010};
        tbl[6]  = '{8'b0111_1000, 11'b10000001100, 24'h000010};
        tbl[7]  = '{8'b0101_1100, 11'b00000000100, 24'h000010};
        tbl[8]  = '{8'b0101_1001, 11'b00000000000, 24'h000010};
        tbl[9]  = '{8'b0101_1000, 11'b00100010100, 24'h000200};
        tbl[10] = '{8'b0101_0010, 11'b00001000000, 24'h000200};
        tbl[11] = '{8'b0101_0000, 11'b01000100100, 24'h000010};
        tbl[12] = '{8'b1000_0000, 11'b00000000000, 24'h000000};
        tbl[13] = '{8'b0101_1000, 11'b01000100100, 24'h000010};
        tbl[14] = '{8'b0100_1000, 11'b00000000100, 24'h000010};

        for (int i = 0; i < 15; i++) begin
            {rst, init_done, ref_req, c0_req, c1_req, wr_done, rd_done, ref_done} = tbl[i].in;
            cycle();
            chk($sformatf("vec%0d", i), {29'd0, flags, cmd_addr},
                {29'd0, tbl[i].exp, tbl[i].addr});
        end

        // C0 write outstanding since the vector table; no done -> abort in BUSY cycle 8.
        {rst, init_done, ref_req, c0_req, c1_req, wr_done, rd_done, ref_done} = 8'b0100_1000;
        for (int i = 3; i <= 7; i++) begin
            cycle();
            chk($sformatf("to_wait%0d", i), {busy, timeout}, 2'b10);
        end
        cycle();
        chk("to_fire", {timeout, c0_done, busy, err}, 4'b1101);
        cycle();
        chk("post_to_grant", {c1_gnt, rd_req, c0_gnt}, 3'b110);
        chk("post_to_addr", cmd_addr, 24'h000200);
        c1_req = 1'b0;

        // Wrong done ignored, then matching done in the last cycle beats the timeout.
        for (int i = 2; i <= 7; i++) begin
            wr_done = (i == 2);
            cycle();
            chk($sformatf("c1_wait%0d", i), {busy, timeout, c1_done}, 3'b100);
        end
        wr_done = 1'b0; rd_done = 1'b1;
        cycle();
        rd_done = 1'b0;
        chk("late_done", {c1_done, timeout, busy, err}, 4'b1001);

        // Round-robin fairness with both clients continuously requesting.
        c0_req = 1'b1; c1_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            seen = 0;
            for (int w = 0; w < 10 && !seen; w++) begin
                cycle();
                seen = c0_gnt | c1_gnt;
            end
            chk($sformatf("rr_seen%0d", k), seen, 1'b1);
            chk($sformatf("rr_gnt%0d", k), {c0_gnt, c1_gnt, wr_req, rd_req},
                (k % 2 == 0) ? 4'b1010 : 4'b0101);
            chk($sformatf("rr_addr%0d", k), cmd_addr,
                (k % 2 == 0) ? 24'h000010 : 24'h000200);
            wr_done = (k % 2 == 0); rd_done = (k % 2 == 1);
            cycle();
            wr_done = 1'b0; rd_done = 1'b0;
            chk($sformatf("rr_done%0d", k), {c0_done, c1_done},
                (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        c0_req = 1'b0; c1_req = 1'b0;

        // Randomized traffic; every cycle is compared against the model inside cycle().
        n = 0;
        repeat (3000) begin
            rst       = ($urandom_range(0, 199) == 0);
            init_done = ($urandom_range(0, 24) != 0);
            wr_done   = ($urandom_range(0, 4) == 0);
            rd_done   = ($urandom_range(0, 4) == 0);
            ref_done  = ($urandom_range(0, 4) == 0);
            if (ref_ack) ref_req = 1'b0;
            else if (!ref_req && $urandom_range(0, 9) == 0) ref_req = 1'b1;
            if (c0_gnt || (c0_req && $urandom_range(0, 19) == 0)) c0_req = 1'b0;
            else if (!c0_req && $urandom_range(0, 2) == 0) begin
                c0_req = 1'b1; c0_we = 1'($urandom); c0_addr = AW'($urandom);
            end
            if (c1_gnt || (c1_req && $urandom_range(0, 19) == 0)) c1_req = 1'b0;
            else if (!c1_req && $urandom_range(0, 2) == 0) begin
                c1_req = 1'b1; c1_we = 1'($urandom); c1_addr = AW'($urandom);
            end
            cycle();
            n++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Shares the SDRAM controller command FSM between two application clients (C0, C1) and the auto-refresh timer.
- Sits between the application-side request generators (write/read data FSMs) and the SDRAM controller.
- Refresh has fixed top priority; C0 and C1 are served round-robin.
- Issues exactly one outstanding operation to the controller at a time, tracks its completion, and returns a done pulse to the owner.

Parameters:
- APP_ADDR_WIDTH, 24, width of client and controller addresses.
- TIMEOUT_CYC, 1024, maximum cycles in BUSY before a forced abort; must be >= 2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_init_done  in  1  SDRAM init complete; no grants while low
- i_ref_req  in  1  refresh request level, held until o_ref_ack
- o_ref_ack  out  1  1-cycle pulse: refresh accepted
- i_c0_req / i_c1_req  in  1  client request level, held until grant
- i_c0_we / i_c1_we  in  1  1 = write, 0 = read; valid while req is high
- i_c0_addr / i_c1_addr  in  APP_ADDR_WIDTH  burst start address
- o_c0_gnt / o_c1_gnt  out  1  1-cycle grant pulse; addr/we captured on this edge
- o_c0_done / o_c1_done  out  1  1-cycle completion pulse
- o_wr_req / o_rd_req / o_ref_req  out  1  1-cycle command pulses to the controller
- o_cmd_addr  out  APP_ADDR_WIDTH  registered address, stable from issue until the next issue
- i_wr_done / i_rd_done / i_ref_done  in  1  controller completion pulses
- o_busy  out  1  high in BUSY
- o_timeout  out  1  1-cycle pulse on abort
- o_err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = 0 (C0 favoured); op and owner registers 0; timeout counter 0.
- States: IDLE, BUSY. Registers op ∈ {REF, WR, RD} and owner ∈ {C0, C1}.
- IDLE arbitration, evaluated only when i_init_done = 1:
  - i_ref_req wins. Next edge: o_ref_ack = 1, o_ref_req = 1, op = REF, go to BUSY.
  - Else, if one client requests, it wins.
  - Else, if both request, the client selected by rr_ptr wins.
  - Winner Cx, next edge: o_cx_gnt = 1; o_wr_req = we or o_rd_req = !we; o_cmd_addr = i_cx_addr; op = WR/RD; owner = x; go to BUSY.
- Latency: request visible in cycle N → grant and command pulse both high in cycle N+1 only.
- BUSY completion:
  - Only the done matching op is honoured; other done pulses are ignored with no state change.
  - On the matching done at edge M: state = IDLE; o_busy = 0 from M+1; for client ops, o_owner_done = 1 in cycle M+1 and rr_ptr = the other client.
  - REF completion produces no client done and leaves rr_ptr unchanged.
- Minimum one IDLE cycle between operations, so back-to-back grant spacing ≥ 2 + controller latency.
- Timeout:
  - Counter clears on entry to BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT_CYC-1 without the matching done: pulse o_timeout, set o_err, pulse o_owner_done for a client op, update rr_ptr as for normal completion, return to IDLE.
  - A matching done arriving in that same cycle takes precedence: no timeout.
- If i_init_done drops while BUSY, the current operation still completes; no new grant is issued while it is low.
- Client req dropping before grant: no grant, no error.
- i_rst mid-operation: immediate return to reset values; no done is emitted for the aborted op.
- o_cmd_addr is not modified by refresh.

Decomposition:
- Shared package sdram_pkg: APP_ADDR_WIDTH default, op encoding constants (OP_REF = 2'd0, OP_WR = 2'd1, OP_RD = 2'd2), state encoding.
- One natural sub-module: rr_arb2, a 2-way round-robin picker taking req[1:0] and rr_ptr and returning one-hot gnt_sel, purely combinational. The pointer stays in the parent.

Test Plan:
- Init gating: i_init_done = 0, i_c0_req = 1 for 20 cycles → no grant. Raise i_init_done in cycle N → o_c0_gnt = o_wr_req = 1 in cycle N+1, o_cmd_addr = i_c0_addr.
- Simultaneous refresh and client: i_ref_req = i_c0_req = i_c1_req = 1 → refresh first (o_ref_ack, o_ref_req). After i_ref_done, C0 is granted; after its done, C1 is granted.
- Round-robin fairness: C0 and C1 both held high (C0 write 0x000010, C1 read 0x000200) for 6 ops → grant order C0, C1, C0, C1, C0, C1, with matching wr/rd pulses and addresses.
- Wrong done ignored: C1 read outstanding, i_wr_done pulsed → stays BUSY. Then i_rd_done → o_c1_done one cycle later.
- Timeout: TIMEOUT_CYC = 8, no done given → o_timeout and o_c0_done in cycle 8 of BUSY, o_err = 1, next grant proceeds. A done in the final cycle → no timeout.
- Reset mid-BUSY: assert i_rst with a C0 op outstanding → all outputs 0 the next cycle, no o_c0_done, rr_ptr = 0.
